// File: rtl/eq_band_sequencer_pkg.sv
// Shared widths, saturation constants and sequencer state encoding for the equalizer.
package eq_pkg;

    localparam int unsigned AUDIO_W = 16;
    localparam int unsigned POT_W   = 12;

    localparam logic [AUDIO_W-1:0] SAT_POS = 16'h7FFF;
    localparam logic [AUDIO_W-1:0] SAT_NEG = 16'h8000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCALE = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : eq_pkg

// File: rtl/eq_band_sequencer_band_scale.sv
// Combinational band gain: squared pot reading (12-bit gain) times signed audio, Q10 result
// saturated to 16 bits.
module band_scale
    import eq_pkg::*;
(
    input  logic        [POT_W-1:0]   i_pot,
    input  logic signed [AUDIO_W-1:0] i_audio,
    output logic signed [AUDIO_W-1:0] o_scaled_c
);

    localparam int unsigned SQ_W    = 2 * POT_W;
    localparam int unsigned PROD_W  = POT_W + 1 + AUDIO_W;
    localparam int unsigned SHIFT   = 10;
    localparam int unsigned TOP_LSB = AUDIO_W + SHIFT - 1;

    logic        [SQ_W-1:0]             w_pot_sq;
    logic        [POT_W-1:0]            w_gain;
    logic signed [PROD_W-1:0]           w_prod;
    logic        [PROD_W-1:TOP_LSB]     w_top;
    logic                               w_ovf;

    assign w_pot_sq = SQ_W'(i_pot) * SQ_W'(i_pot);
    assign w_gain   = POT_W'(w_pot_sq >> POT_W);

    // Gain is unsigned, so a zero sign bit keeps it positive in the signed multiply.
    assign w_prod   = PROD_W'($signed({1'b0, w_gain})) * PROD_W'(i_audio);

    assign w_top    = w_prod[PROD_W-1:TOP_LSB];
    assign w_ovf    = ~((&w_top) | ~(|w_top));

    assign o_scaled_c = w_ovf ? (w_prod[PROD_W-1] ? SAT_NEG : SAT_POS)
                              : AUDIO_W'(w_prod >>> SHIFT);

endmodule : band_scale

// File: rtl/eq_band_sequencer.sv
// Time-multiplexed scale-and-sum for the equalizer: snapshots all bands on sample_vld, runs
// them through one shared band_scale, accumulates and presents one saturated 16-bit sample.
module eq_band_sequencer
    import eq_pkg::*;
#(
    parameter int unsigned NUM_BANDS = 5
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           sample_vld,
    input  logic [AUDIO_W*NUM_BANDS-1:0]   band_audio,
    input  logic [POT_W*NUM_BANDS-1:0]     pots,
    output logic [AUDIO_W-1:0]             eq_out,
    output logic                           eq_vld,
    output logic                           busy,
    output logic                           overrun
);

    localparam int unsigned ACC_W = AUDIO_W + $clog2(NUM_BANDS);
    localparam int unsigned IDX_W = $clog2(NUM_BANDS);

    localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(32'sd32767);
    localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(-32'sd32768);

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic        [IDX_W-1:0]         r_band_idx;
    logic signed [ACC_W-1:0]         r_acc;
    logic [AUDIO_W*NUM_BANDS-1:0]    r_audio;
    logic [POT_W*NUM_BANDS-1:0]      r_pots;
    logic        [AUDIO_W-1:0]       r_eq_out;
    logic                            r_eq_vld;
    logic                            r_busy;
    logic                            r_overrun;

    logic signed [AUDIO_W-1:0]       w_audio_sel;
    logic        [POT_W-1:0]         w_pot_sel;
    logic signed [AUDIO_W-1:0]       w_scaled;
    logic                            w_last_band;
    logic        [AUDIO_W-1:0]       w_sat;

    assign w_audio_sel = r_audio[r_band_idx * AUDIO_W +: AUDIO_W];
    assign w_pot_sel   = r_pots[r_band_idx * POT_W +: POT_W];
    assign w_last_band = (r_band_idx == IDX_W'(NUM_BANDS - 1));

    band_scale u_band_scale (
        .i_pot      (w_pot_sel),
        .i_audio    (w_audio_sel),
        .o_scaled_c (w_scaled)
    );

    assign w_sat = (r_acc > ACC_MAX) ? SAT_POS :
                   (r_acc < ACC_MIN) ? SAT_NEG : r_acc[AUDIO_W-1:0];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (sample_vld) w_state_nxt = SCALE;
            SCALE:   if (w_last_band) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Snapshot, accumulate and output datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_band_idx <= '0;
            r_acc      <= '0;
            r_audio    <= '0;
            r_pots     <= '0;
            r_eq_out   <= '0;
            r_eq_vld   <= 1'b0;
            r_busy     <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_eq_vld <= 1'b0;
            r_busy   <= (w_state_nxt != IDLE);
            if (sample_vld && (r_state != IDLE)) begin
                r_overrun <= 1'b1;
            end
            unique case (r_state)
                IDLE: begin
                    if (sample_vld) begin
                        r_audio    <= band_audio;
                        r_pots     <= pots;
                        r_acc      <= '0;
                        r_band_idx <= '0;
                    end
                end
                SCALE: begin
                    r_acc      <= r_acc + ACC_W'(w_scaled);
                    r_band_idx <= w_last_band ? '0 : r_band_idx + IDX_W'(1);
                end
                DONE: begin
                    r_eq_out <= w_sat;
                    r_eq_vld <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign eq_out  = r_eq_out;
    assign eq_vld  = r_eq_vld;
    assign busy    = r_busy;
    assign overrun = r_overrun;

endmodule : eq_band_sequencer

// File: tb/tb_eq_band_sequencer.sv
// Self-checking bench for eq_band_sequencer: directed corner cases plus random samples,
// compared against an arithmetic reference model of the band gain and saturated sum.
module tb_eq_band_sequencer;
    import eq_pkg::*;

    localparam int unsigned NB = 5;

    logic                  clk;
    logic                  rst;
    logic                  sample_vld;
    logic [AUDIO_W*NB-1:0] band_audio;
    logic [POT_W*NB-1:0]   pots;
    logic [AUDIO_W-1:0]    eq_out;
    logic                  eq_vld;
    logic                  busy;
    logic                  overrun;

    int n_checks = 0;
    int n_fails  = 0;
    int aud [NB];
    int pt  [NB];
    int exp_ovr  = 0;

    eq_band_sequencer #(.NUM_BANDS(NB)) dut (
        .clk        (clk),
        .rst        (rst),
        .sample_vld (sample_vld),
        .band_audio (band_audio),
        .pots       (pots),
        .eq_out     (eq_out),
        .eq_vld     (eq_vld),
        .busy       (busy),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int clamp16(input int v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Reference: gain = floor(pot^2 / 4096), band = clamp(floor(gain*audio / 1024)), sum clamped.
    function automatic int model();
        int s;
        s = 0;
        for (int k = 0; k < NB; k++) begin
            int g;
            g = (pt[k] * pt[k]) / 4096;
            s += clamp16((g * aud[k]) >>> 10);
        end
        return clamp16(s);
    endfunction

    task automatic drive_inputs();
        for (int k = 0; k < NB; k++) begin
            band_audio[k*AUDIO_W +: AUDIO_W] = 16'(aud[k]);
            pots[k*POT_W +: POT_W]           = 12'(pt[k]);
        end
    endtask

    task automatic scramble();
        band_audio = 80'({$urandom(), $urandom(), $urandom()});
        pots       = 60'({$urandom(), $urandom()});
    endtask

    // Issue one sample and follow it edge by edge; ovr_at >= 0 injects a second pulse.
    task automatic run_sample(input string tag, input int ovr_at);
        int exp;
        exp = model();
        drive_inputs();
        sample_vld = 1'b1;
        for (int i = 0; i <= int'(NB) + 2; i++) begin
            @(posedge clk);
            #1;
            if (ovr_at >= 0 && i == ovr_at + 1) exp_ovr = 1;
            sample_vld = 1'b0;
            if (i == 0) scramble();
            if (i == ovr_at) begin
                scramble();
                sample_vld = 1'b1;
            end
            chk({tag, " busy"},    int'(busy),    int'(i <= int'(NB)));
            chk({tag, " eq_vld"},  int'(eq_vld),  int'(i == int'(NB) + 1));
            chk({tag, " overrun"}, int'(overrun), exp_ovr);
            if (i >= int'(NB) + 1) chk({tag, " eq_out"}, int'($signed(eq_out)), exp);
        end
    endtask

    task automatic set_all(input int a, input int p);
        for (int k = 0; k < NB; k++) begin
            aud[k] = a;
            pt[k]  = p;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sample_vld = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_ovr = 0;
    endtask

    initial begin
        rst = 1'b1;
        sample_vld = 1'b0;
        band_audio = '0;
        pots = '0;
        #2;
        chk("rst eq_out",  int'(eq_out),  0);
        chk("rst eq_vld",  int'(eq_vld),  0);
        chk("rst busy",    int'(busy),    0);
        chk("rst overrun", int'(overrun), 0);
        do_reset();

        set_all(1000, 12'h800);
        run_sample("unity", -1);

        set_all(0, 0);
        for (int k = 0; k < NB; k++) aud[k] = 100 * (k + 1);
        pt[2] = 12'h800;
        run_sample("band2_unity", -1);

        set_all(1000, 0);
        pt[2] = 12'hFFF;
        run_sample("band2_max", -1);

        set_all(1234, 0);
        aud[0] = -1;
        pt[0]  = 12'hFFF;
        run_sample("floor_neg", -1);

        set_all(20000, 12'h800);
        run_sample("sum_sat_pos", -1);

        set_all(-20000, 12'h800);
        run_sample("sum_sat_neg", -1);

        set_all(0, 0);
        aud[3] = 32767;
        pt[3]  = 12'hFFF;
        run_sample("band_sat", -1);

        set_all(700, 12'h900);
        aud[1] = -3000;
        run_sample("overrun_scale", 1);

        // Abort a sample mid-scan; nothing from it may escape.
        set_all(500, 12'h800);
        drive_inputs();
        sample_vld = 1'b1;
        @(posedge clk);
        #1;
        sample_vld = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst eq_out",  int'(eq_out),  0);
        chk("midrst eq_vld",  int'(eq_vld),  0);
        chk("midrst busy",    int'(busy),    0);
        chk("midrst overrun", int'(overrun), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_ovr = 0;
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 10; i++) begin
                @(posedge clk);
                #1;
                seen += int'(eq_vld);
            end
            chk("midrst no eq_vld", seen, 0);
        end

        set_all(321, 12'hA00);
        run_sample("post_rst", -1);

        set_all(-900, 12'h7FF);
        run_sample("overrun_done", int'(NB));

        do_reset();
        for (int n = 0; n < 20; n++) begin
            for (int k = 0; k < NB; k++) begin
                aud[k] = int'($urandom_range(65535)) - 32768;
                pt[k]  = int'($urandom_range(4095));
                if ($urandom_range(3) == 0) pt[k] = 4095;
            end
            run_sample("random", -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_eq_band_sequencer
